// File: rtl/opb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// opb_rr_arbiter -- round-robin arbiter and bus watchdog for the shared OPB
// segment (master 0 = EPB32-to-OPB bridge, others = DMA/config masters).
//
// Ports
//   OPB_Clk, OPB_Rst             clock (rising edge), async active-high reset
//   M_request/M_busLock/M_select per-master request, lock and bus-in-use
//   OPB_xferAck/errAck/retry     slave responses that feed the watchdog
//   OPB_MGrant                   registered one-hot (or zero) grant
//   OPB_timeout                  registered one-cycle watchdog pulse
//   arb_owner                    index of the current / last bus owner
//   arb_busy                     high while in GRANT or BUSY
//   arb_err                      one-cycle pulse on select protocol violation
// ---------------------------------------------------------------------------

// Per-master ownership decode: flags whether this master is the owner and
// whether it is driving M_select without owning the bus.
module opb_rr_lane #(
   parameter int IDX_W = 1,
   parameter int IDX   = 0
) (
   input  logic [IDX_W-1:0] owner,
   input  logic             sel,
   output logic             is_owner,
   output logic             nonowner_sel
);
   assign is_owner     = (owner == IDX_W'(IDX));
   assign nonowner_sel = sel && !is_owner;
endmodule

module opb_rr_arbiter #(
   parameter int NUM_MASTERS    = 2,
   parameter int IDX_W          = 1,
   parameter int GRANT_WAIT     = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                   OPB_Clk,
   input  logic                   OPB_Rst,
   input  logic [NUM_MASTERS-1:0] M_request,
   input  logic [NUM_MASTERS-1:0] M_busLock,
   input  logic [NUM_MASTERS-1:0] M_select,
   input  logic                   OPB_xferAck,
   input  logic                   OPB_errAck,
   input  logic                   OPB_retry,
   output logic [NUM_MASTERS-1:0] OPB_MGrant,
   output logic                   OPB_timeout,
   output logic [IDX_W-1:0]       arb_owner,
   output logic                   arb_busy,
   output logic                   arb_err
);

   typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

   state_t                 state;
   logic [3:0]             wait_cnt;
   logic [7:0]             wd_cnt;

   logic [NUM_MASTERS-1:0] owner_oh;
   logic [NUM_MASTERS-1:0] nonowner_sel;
   logic [NUM_MASTERS-1:0] winner_oh;
   logic [IDX_W-1:0]       winner;
   int                     cand;
   logic                   owner_req, owner_sel, owner_lock;
   logic                   multi_sel, viol, any_ack;

   for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_lane
      opb_rr_lane #(.IDX_W(IDX_W), .IDX(i)) u_lane (
         .owner        (arb_owner),
         .sel          (M_select[i]),
         .is_owner     (owner_oh[i]),
         .nonowner_sel (nonowner_sel[i])
      );
   end

   assign owner_req  = |(M_request & owner_oh);
   assign owner_sel  = |(M_select  & owner_oh);
   assign owner_lock = |(M_busLock & owner_oh);
   // x & (x-1) clears the lowest set bit; anything left means >1 select
   assign multi_sel  = (M_select & (M_select - NUM_MASTERS'(1))) != '0;
   assign viol       = (|nonowner_sel) || multi_sel;
   assign any_ack    = OPB_xferAck || OPB_errAck || OPB_retry;
   assign arb_busy   = (state != IDLE);

   // Rotating priority: scan distances N..1 from the last owner so the
   // nearest requester after it is the last assignment and wins. The owner
   // itself sits at distance N, so a lone requester always wins again.
   always_comb begin
      winner = arb_owner;
      cand   = 0;
      for (int k = NUM_MASTERS; k >= 1; k--) begin
         cand = int'(arb_owner) + k;
         if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
         for (int j = 0; j < NUM_MASTERS; j++)
            if (M_request[j] && (j == cand)) winner = IDX_W'(j);
      end
   end

   always_comb begin
      winner_oh = '0;
      for (int j = 0; j < NUM_MASTERS; j++)
         winner_oh[j] = (winner == IDX_W'(j));
   end

   always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
      if (OPB_Rst) begin
         state       <= IDLE;
         OPB_MGrant  <= '0;
         OPB_timeout <= 1'b0;
         arb_owner   <= IDX_W'(NUM_MASTERS - 1);
         arb_err     <= 1'b0;
         wait_cnt    <= '0;
         wd_cnt      <= '0;
      end else begin
         // Violations are only reported; they never steer the FSM.
         arb_err     <= viol;
         OPB_timeout <= 1'b0;
         case (state)
            IDLE: begin
               wd_cnt   <= '0;
               wait_cnt <= '0;
               if (|M_request) begin
                  OPB_MGrant <= winner_oh;
                  arb_owner  <= winner;
                  state      <= GRANT;
               end else begin
                  OPB_MGrant <= '0;
               end
            end
            GRANT: begin
               if (owner_sel) begin
                  OPB_MGrant <= '0;
                  wd_cnt     <= '0;
                  state      <= BUSY;
               end else if (!owner_req || (wait_cnt == 4'(GRANT_WAIT - 1))) begin
                  // Owner index is kept so the next round rotates past it.
                  OPB_MGrant <= '0;
                  state      <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            BUSY: begin
               if (owner_sel) begin
                  // Ack beats the threshold when both land together.
                  if (any_ack) begin
                     wd_cnt <= '0;
                  end else if (wd_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                     OPB_timeout <= 1'b1;
                     wd_cnt      <= '0;
                  end else begin
                     wd_cnt <= wd_cnt + 8'd1;
                  end
               end else if (owner_lock && owner_req) begin
                  // Locked owner keeps the bus: regrant without rotating.
                  OPB_MGrant <= owner_oh;
                  wait_cnt   <= '0;
                  wd_cnt     <= '0;
                  state      <= GRANT;
               end else begin
                  wd_cnt <= '0;
                  state  <= IDLE;
               end
            end
            default: begin
               OPB_MGrant <= '0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_opb_rr_arbiter.sv
module tb_opb_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req, lock, sel;
   logic       xack, eack, rtry;
   logic [1:0] gnt;
   logic       tmo, own, busy, err;

   opb_rr_arbiter #(
      .NUM_MASTERS(2), .IDX_W(1), .GRANT_WAIT(4), .TIMEOUT_CYCLES(16)
   ) dut (
      .OPB_Clk     (clk),
      .OPB_Rst     (rst),
      .M_request   (req),
      .M_busLock   (lock),
      .M_select    (sel),
      .OPB_xferAck (xack),
      .OPB_errAck  (eack),
      .OPB_retry   (rtry),
      .OPB_MGrant  (gnt),
      .OPB_timeout (tmo),
      .arb_owner   (own),
      .arb_busy    (busy),
      .arb_err     (err)
   );

   always #5 clk = ~clk;

   typedef enum int {F_GNT, F_TMO, F_OWN, F_BUSY, F_ERR} fld_t;
   typedef struct {
      string tag;
      fld_t  fld;
      int    val;
   } exp_t;

   exp_t sb[$];
   int   ncomp = 0;
   int   nfail = 0;

   function automatic int obs(fld_t f);
      case (f)
         F_GNT:   return int'(gnt);
         F_TMO:   return int'(tmo);
         F_OWN:   return int'(own);
         F_BUSY:  return int'(busy);
         default: return int'(err);
      endcase
   endfunction

   task automatic ex(input string tag, input fld_t f, input int v);
      exp_t e;
      e.tag = tag; e.fld = f; e.val = v;
      sb.push_back(e);
   endtask

   // Compare every queued expectation against the outputs as they stand now.
   task automatic drain();
      exp_t e;
      int   o;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = obs(e.fld);
         ncomp++;
         assert (o === e.val) else begin
            nfail++;
            $error("FAIL %s: got %0d want %0d", e.tag, o, e.val);
         end
      end
   endtask

   // One clock edge, then sample 1 time unit later.
   task automatic cyc();
      @(posedge clk);
      #1;
      drain();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      rst = 1'b1; req = '0; lock = '0; sel = '0;
      xack = 1'b0; eack = 1'b0; rtry = 1'b0;
      #2;
      ex("rst_gnt", F_GNT, 0); ex("rst_own", F_OWN, 1); ex("rst_busy", F_BUSY, 0);
      ex("rst_err", F_ERR, 0); ex("rst_tmo", F_TMO, 0);
      drain();
      cyc(); cyc();

      // First arbitration after reset goes to master 0.
      rst = 1'b0; req = 2'b11;
      ex("first_gnt", F_GNT, 1); ex("first_own", F_OWN, 0); ex("first_busy", F_BUSY, 1);
      cyc();

      // M0 selects for 3 cycles, grant is dropped while busy.
      sel = 2'b01;
      for (int k = 0; k < 3; k++) begin
         ex("busy_gnt", F_GNT, 0); ex("busy_busy", F_BUSY, 1); ex("busy_err", F_ERR, 0);
         cyc();
      end
      sel = 2'b00;
      ex("rel_gnt", F_GNT, 0); ex("rel_busy", F_BUSY, 0);
      cyc();
      // Rotation to M1.
      ex("rot_gnt", F_GNT, 2); ex("rot_own", F_OWN, 1);
      cyc();

      // M1 never selects: grant held 4 cycles total then revoked.
      for (int k = 0; k < 3; k++) begin
         ex("wait_gnt", F_GNT, 2);
         cyc();
      end
      ex("revoke_gnt", F_GNT, 0); ex("revoke_busy", F_BUSY, 0); ex("revoke_own", F_OWN, 1);
      cyc();
      ex("after_revoke_gnt", F_GNT, 1); ex("after_revoke_own", F_OWN, 0);
      cyc();

      // Locked M0 is regranted while M1 keeps requesting.
      sel = 2'b01; lock = 2'b01;
      ex("lock_busy_gnt", F_GNT, 0);
      cyc();
      ex("lock_busy2_gnt", F_GNT, 0);
      cyc();
      sel = 2'b00;
      ex("lock_regnt", F_GNT, 1); ex("lock_own", F_OWN, 0); ex("lock_busy", F_BUSY, 1);
      cyc();

      // Watchdog: pulse on the 16th silent BUSY cycle, repeating.
      sel = 2'b01;
      ex("wd_entry_gnt", F_GNT, 0);
      cyc();
      for (int p = 0; p < 2; p++) begin
         for (int k = 1; k <= 15; k++) begin
            ex("wd_quiet", F_TMO, 0);
            cyc();
         end
         ex("wd_pulse", F_TMO, 1);
         cyc();
      end
      // xferAck on the 15th cycle suppresses the pulse.
      for (int k = 1; k <= 14; k++) begin
         ex("wd_pre_ack", F_TMO, 0);
         cyc();
      end
      xack = 1'b1;
      ex("wd_ack15", F_TMO, 0);
      cyc();
      xack = 1'b0;
      ex("wd_no_pulse", F_TMO, 0);
      cyc();
      // Ack at the threshold cycle wins over the timeout.
      for (int k = 1; k <= 14; k++) begin
         ex("wd_run", F_TMO, 0);
         cyc();
      end
      rtry = 1'b1;
      ex("wd_ack_thresh", F_TMO, 0);
      cyc();
      rtry = 1'b0;
      ex("wd_after_thresh", F_TMO, 0);
      cyc();

      // Non-owner select while M0 owns: error pulse, grants untouched.
      sel = 2'b11;
      ex("err_pulse", F_ERR, 1); ex("err_gnt", F_GNT, 0); ex("err_busy", F_BUSY, 1);
      cyc();
      sel = 2'b01;
      ex("err_clear", F_ERR, 0); ex("err_own", F_OWN, 0);
      cyc();

      // Asynchronous reset mid-BUSY.
      #2;
      rst = 1'b1;
      #1;
      ex("mid_rst_gnt", F_GNT, 0); ex("mid_rst_busy", F_BUSY, 0); ex("mid_rst_own", F_OWN, 1);
      ex("mid_rst_tmo", F_TMO, 0); ex("mid_rst_err", F_ERR, 0);
      drain();
      sel = '0; req = '0; lock = '0;
      ex("held_rst_gnt", F_GNT, 0);
      cyc();

      // Lone requester M1 is granted, drops, and is granted again.
      rst = 1'b0; req = 2'b10;
      ex("solo_gnt", F_GNT, 2); ex("solo_own", F_OWN, 1);
      cyc();
      req = 2'b00;
      ex("solo_drop_gnt", F_GNT, 0); ex("solo_drop_busy", F_BUSY, 0);
      cyc();
      req = 2'b10;
      ex("solo_regnt", F_GNT, 2); ex("solo_reown", F_OWN, 1);
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
      $finish;
   end

endmodule
